chan_select_scan: RTL and testbench
===================================

Name: chan_select_scan

Overview:
Parametrised N-channel output selector, the successor to the fixed two-source dice/traffic-light mux. It routes one of CHANNELS WIDTH-bit source buses to a registered result. The channel is chosen in one of four modes: manual select, timed auto-scan, button-step, or freeze. It sits at the top level between the source blocks (dice, traffic lights, counters) and the board display/LED outputs.

Parameters:
CHANNELS, 4, number of source channels (>=1)
WIDTH, 3, bits per channel and width of result
DWELL, 8, clock cycles each channel is held in auto-scan mode (>=1)
SEL_W, derived localparam = max(1, clog2(CHANNELS)), channel index width; not overridable

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  asynchronous active-high reset; clears all state immediately, independent of clk
data_in  input  CHANNELS*WIDTH  packed sources; channel k at bits [k*WIDTH +: WIDTH]
mode  input  2  00 manual, 01 auto-scan, 10 step, 11 freeze
sel  input  SEL_W  channel index, used in manual mode only
button  input  1  step request, synchronous to clk; used in step mode only
result  output  WIDTH  registered selected channel data
cur_ch  output  SEL_W  registered index of the channel currently driving result
switched  output  1  one-cycle pulse following any change of cur_ch

Behaviour:
- Reset (async, active-high): result=0, cur_ch=0, switched=0, dwell counter=0, button history register=0. Takes effect without a clock edge. Outputs hold these values until the first rising edge after rst deasserts.
- Per edge, next channel nxt is computed from mode. Then cur_ch<=nxt and result<=data_in slice[nxt] on the same edge, so result and cur_ch are always consistent.
- Latency from data_in to result is 1 cycle in every mode except freeze.
- Manual (00): nxt=sel if sel<CHANNELS, else nxt=cur_ch (an out-of-range sel is ignored and holds). Dwell counter is forced to 0.
- Auto-scan (01): dwell counter counts 0..DWELL-1.
  - At count==DWELL-1: counter->0 and nxt=cur_ch+1, wrapping CHANNELS-1->0.
  - Otherwise: counter+1 and nxt=cur_ch.
  - Each channel is held for exactly DWELL edges. On entry from another mode the counter starts at 0.
  - DWELL=1 advances every edge.
- Step (10): rise = button & ~btn_q, where btn_q is the button registered once.
  - Each rise: nxt=cur_ch+1 with wrap.
  - A held button advances once only.
  - Dwell counter forced to 0.
- Freeze (11): nxt=cur_ch and result holds its value; data_in changes are not reflected. Dwell counter forced to 0.
- btn_q updates every edge in all modes. A button already high when mode switches to step does not cause a step.
- Mode changes take effect on the edge at which the new mode is sampled. There is no extra latency.
- switched <= (nxt != cur_ch) on every edge. Re-selecting the same channel gives no pulse.
- CHANNELS=1: cur_ch is always 0, switched is never asserted, result follows channel 0 (except in freeze).
- Advance arithmetic is modulo CHANNELS, not 2^SEL_W. For non-power-of-2 CHANNELS, index CHANNELS is never produced.

Test Plan:
Common setup: CHANNELS=4, WIDTH=3, DWELL=3; data_in ch0=001, ch1=010, ch2=011, ch3=100.
1. Assert rst -> result=000, cur_ch=0, switched=0. Deassert, mode=00, sel=0 -> after 1 edge result=001, switched=0.
2. Manual, sel=2 -> next edge cur_ch=2, result=011, switched=1 for exactly one cycle. Then sel=3 -> result=100. In a CHANNELS=3 instance, sel=3 -> cur_ch and result unchanged, no pulse.
3. Auto-scan from cur_ch=0 -> cur_ch per edge is 0,0,1,1,1,2,2,2,3,3,3,0 (the counter starts at 0 on entry, so the first channel shows the remaining dwell). switched pulses on every channel change; result tracks, 3->0 wraps to 001.
4. Step, cur_ch=3 -> button held high for 5 cycles gives one advance, to 0. Then three 1-cycle pulses give 1,2,3. A button high before entering step gives no advance.
5. Freeze on cur_ch=1; change ch1 to 111 -> result stays 010 for 10 edges, switched=0. Return to manual with sel=1 -> result=111 after 1 edge.
6. Mid auto-scan at cur_ch=2, assert rst between clock edges -> result=000, cur_ch=0 immediately without an edge. After release, the dwell count restarts from 0.

Source files
------------

// File: rtl/chan_select_scan_if.sv
// Bundle of source/control inputs and registered outputs for chan_select_scan.
//   master : block that drives the sources and the mode/sel/button controls
//   slave  : the selector itself
// Signals:
//   data_in  CHANNELS*WIDTH packed sources, channel k at [k*WIDTH +: WIDTH]
//   mode     00 manual, 01 auto-scan, 10 step, 11 freeze
//   sel      channel index for manual mode
//   button   step request (synchronous to clk)
//   result   registered data of the selected channel
//   cur_ch   registered index of the channel driving result
//   switched one-cycle pulse after cur_ch changes
interface chan_select_scan_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 3
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [1:0]                mode;
  logic [SEL_W-1:0]          sel;
  logic                      button;
  logic [WIDTH-1:0]          result;
  logic [SEL_W-1:0]          cur_ch;
  logic                      switched;

  modport master (
    output data_in, mode, sel, button,
    input  result, cur_ch, switched
  );

  modport slave (
    input  data_in, mode, sel, button,
    output result, cur_ch, switched
  );
endinterface

// File: rtl/chan_select_scan.sv
// N-channel output selector feeding the board display/LEDs.
// Picks one of CHANNELS WIDTH-bit sources into a registered result using one
// of four modes: manual select, timed auto-scan, button step, or freeze.
// Ports:
//   clk  system clock, all state updates on the rising edge
//   rst  asynchronous active-high reset
//   bus  chan_select_scan_if.slave (data_in/mode/sel/button in,
//        result/cur_ch/switched out)
module chan_select_scan #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 3,
  parameter int DWELL    = 8
) (
  input  logic               clk,
  input  logic               rst,
  chan_select_scan_if.slave  bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_SCAN   = 2'b01;
  localparam logic [1:0] M_STEP   = 2'b10;
  localparam logic [1:0] M_FREEZE = 2'b11;

  // Sources viewed as an indexable array; same bit layout as data_in.
  logic [CHANNELS-1:0][WIDTH-1:0] src;
  assign src = bus.data_in;

  logic [WIDTH-1:0] result_q, result_d;
  logic [SEL_W-1:0] cur_ch_q, nxt_ch;
  logic             switched_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic [SEL_W-1:0] adv_ch;

  // Advance wraps modulo CHANNELS, so an index >= CHANNELS never appears
  // even when CHANNELS is not a power of two.
  assign adv_ch = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;

  always_comb begin
    nxt_ch = cur_ch_q;
    cnt_d  = '0;
    unique case (bus.mode)
      M_MANUAL: begin
        // Out-of-range sel is ignored; the current channel holds.
        if (32'(bus.sel) < CHANNELS) nxt_ch = bus.sel;
      end
      M_SCAN: begin
        if (cnt_q == LAST_CNT) begin
          nxt_ch = adv_ch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      M_STEP: begin
        // Rising edge only: a held button advances once.
        if (bus.button && !btn_q) nxt_ch = adv_ch;
      end
      default: ;  // freeze: hold channel
    endcase
  end

  // Freeze also holds the data, so source changes are not reflected.
  always_comb begin
    result_d = src[nxt_ch];
    if (bus.mode == M_FREEZE) result_d = result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      cur_ch_q   <= '0;
      switched_q <= 1'b0;
      cnt_q      <= '0;
      btn_q      <= 1'b0;
    end else begin
      result_q   <= result_d;
      cur_ch_q   <= nxt_ch;
      switched_q <= (nxt_ch != cur_ch_q);
      cnt_q      <= cnt_d;
      btn_q      <= bus.button;  // tracked in every mode
    end
  end

  assign bus.result   = result_q;
  assign bus.cur_ch   = cur_ch_q;
  assign bus.switched = switched_q;
endmodule

// File: tb/tb_chan_select_scan.sv
module tb_chan_select_scan;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chan_select_scan_if #(.CHANNELS(4), .WIDTH(3)) b4 ();
  chan_select_scan_if #(.CHANNELS(3), .WIDTH(3)) b3 ();

  chan_select_scan #(.CHANNELS(4), .WIDTH(3), .DWELL(3)) dut4 (
    .clk(clk), .rst(rst), .bus(b4));
  chan_select_scan #(.CHANNELS(3), .WIDTH(3), .DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3));

  // 3-channel instance: always manual, shares sel and the low three sources.
  assign b3.data_in = b4.data_in[8:0];
  assign b3.sel     = b4.sel;
  assign b3.mode    = 2'b00;
  assign b3.button  = 1'b0;

  typedef struct {
    string      name;
    logic [2:0] res;
    logic [1:0] ch;
    logic       sw;
    bit         c3;
    logic [2:0] res3;
    logic [1:0] ch3;
    logic       sw3;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  // Monitor: every clock edge (or an explicit between-edge check) presents
  // a new output set; pop and compare if an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (b4.result !== e.res || b4.cur_ch !== e.ch || b4.switched !== e.sw) begin
          n_bad++;
          $display("FAIL %s: got res=%b ch=%0d sw=%b, want res=%b ch=%0d sw=%b",
                   e.name, b4.result, b4.cur_ch, b4.switched, e.res, e.ch, e.sw);
        end
        if (e.c3) begin
          n_cmp++;
          if (b3.result !== e.res3 || b3.cur_ch !== e.ch3 || b3.switched !== e.sw3) begin
            n_bad++;
            $display("FAIL %s(ch3): got res=%b ch=%0d sw=%b, want res=%b ch=%0d sw=%b",
                     e.name, b3.result, b3.cur_ch, b3.switched, e.res3, e.ch3, e.sw3);
          end
        end
      end
    end
  end

  task automatic push(input string nm, input logic [2:0] r, input logic [1:0] c,
                      input logic s, input bit c3, input logic [2:0] r3,
                      input logic [1:0] ch3, input logic s3);
    exp_t e;
    e.name = nm; e.res = r; e.ch = c; e.sw = s;
    e.c3 = c3; e.res3 = r3; e.ch3 = ch3; e.sw3 = s3;
    q.push_back(e);
  endtask

  // One clock: expectation for the coming edge, then back to the negedge
  // where the next inputs are applied.
  task automatic cyc(input string nm, input logic [2:0] r, input logic [1:0] c,
                     input logic s, input bit c3 = 1'b0, input logic [2:0] r3 = 3'b0,
                     input logic [1:0] ch3 = 2'b0, input logic s3 = 1'b0);
    push(nm, r, c, s, c3, r3, ch3, s3);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] dv [4];
  logic [1:0] seq [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev;
    dv = '{3'b001, 3'b010, 3'b011, 3'b100};
    b4.data_in = {3'b100, 3'b011, 3'b010, 3'b001};
    b4.mode    = 2'b00;
    b4.sel     = 2'd0;
    b4.button  = 1'b0;

    // 1. reset, then first selection
    #1 rst = 1'b1;
    #1 push("reset", 3'b000, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    rst = 1'b0;
    cyc("first", 3'b001, 2'd0, 1'b0, 1'b1, 3'b001, 2'd0, 1'b0);

    // 2. manual selection, out-of-range sel on the 3-channel instance
    b4.sel = 2'd2;
    cyc("man2", 3'b011, 2'd2, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1);
    cyc("man2_hold", 3'b011, 2'd2, 1'b0, 1'b1, 3'b011, 2'd2, 1'b0);
    b4.sel = 2'd3;
    cyc("man3", 3'b100, 2'd3, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0);
    cyc("man3_hold", 3'b100, 2'd3, 1'b0, 1'b1, 3'b011, 2'd2, 1'b0);

    // 3. auto-scan from channel 0
    b4.sel = 2'd0;
    cyc("man0", 3'b001, 2'd0, 1'b1);
    b4.mode = 2'b01;
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("scan%0d", i), dv[seq[i]], seq[i], (i == 0) ? 1'b0 : (seq[i] != seq[i-1]));
    end

    // 4. step mode
    b4.mode = 2'b00; b4.sel = 2'd3;
    cyc("pre_step", 3'b100, 2'd3, 1'b1);
    b4.mode = 2'b10; b4.button = 1'b1;
    cyc("hold0", 3'b001, 2'd0, 1'b1);
    for (int i = 1; i < 5; i++) cyc($sformatf("hold%0d", i), 3'b001, 2'd0, 1'b0);
    b4.button = 1'b0;
    cyc("rel", 3'b001, 2'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      b4.button = 1'b1;
      cyc($sformatf("pulse%0d", i), dv[i], 2'(i), 1'b1);
      b4.button = 1'b0;
      cyc($sformatf("pulse%0d_lo", i), dv[i], 2'(i), 1'b0);
    end
    b4.mode = 2'b00; b4.button = 1'b1;
    cyc("btn_pre", 3'b100, 2'd3, 1'b0);
    b4.mode = 2'b10;
    cyc("btn_entry", 3'b100, 2'd3, 1'b0);
    cyc("btn_entry2", 3'b100, 2'd3, 1'b0);
    b4.button = 1'b0;

    // 5. freeze ignores source changes
    b4.mode = 2'b00; b4.sel = 2'd1;
    cyc("pre_frz", 3'b010, 2'd1, 1'b1);
    b4.mode = 2'b11;
    b4.data_in = {3'b100, 3'b011, 3'b111, 3'b001};
    dv[1] = 3'b111;
    for (int i = 0; i < 10; i++) cyc($sformatf("frz%0d", i), 3'b010, 2'd1, 1'b0);
    b4.mode = 2'b00;
    cyc("unfrz", 3'b111, 2'd1, 1'b0);

    // 6. async reset in the middle of auto-scan
    b4.sel = 2'd0;
    cyc("man0b", 3'b001, 2'd0, 1'b1);
    b4.mode = 2'b01;
    for (int i = 0; i < 6; i++)
      cyc($sformatf("scanb%0d", i), dv[seq[i]], seq[i], (i == 0) ? 1'b0 : (seq[i] != seq[i-1]));
    cyc("scanb_mid", 3'b011, 2'd2, 1'b0);
    #1 rst = 1'b1;
    #1 push("async_rst", 3'b000, 2'd0, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0);
    ->chk_ev;
    #2;
    cyc("rst_hold", 3'b000, 2'd0, 1'b0);
    rst = 1'b0;
    cyc("post_rst0", 3'b001, 2'd0, 1'b0);
    cyc("post_rst1", 3'b001, 2'd0, 1'b0);
    cyc("post_rst2", 3'b111, 2'd1, 1'b1);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
